// File: rtl/test_port_writer_if.sv
// Signal bundle between the test-port stream driver and its producer/memory side.
// Input stream: a result word transfers on a rising edge where in_valid && in_ready.
interface test_port_writer_if;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        stall;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic        busy;
  logic        done;
  logic [9:0]  word_count;
  logic [2:0]  state_dbg;

  modport master (
    input  start, in_valid, in_data, in_last, stall,
    output in_ready, addr, data, wen, busy, done, word_count, state_dbg
  );

  modport slave (
    output start, in_valid, in_data, in_last, stall,
    input  in_ready, addr, data, wen, busy, done, word_count, state_dbg
  );
endinterface

// File: rtl/test_port_writer.sv
// Framed result-stream writer: BEGIN_SYMBOL, buffered result words, END_SYMBOL,
// each issued as an isolated wen pulse on the data-memory test port.
module test_port_writer #(
  parameter logic [29:0] TEST_PORT    = 30'h40,
  parameter logic [31:0] BEGIN_SYMBOL = 32'h00000932,
  parameter logic [31:0] END_SYMBOL   = 32'h00000D5D,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic clk,
  input logic rst,
  test_port_writer_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BEGIN = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [2:0]       ret_q, ret_d;
  logic             wen_q, wen_d;
  logic [31:0]      data_q, data_d;
  logic [9:0]       wc_q, wc_d;
  logic [32:0]      mem_q [FIFO_DEPTH];
  logic [32:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;

  logic        in_ready;
  logic        push;
  logic        pop;
  logic        complete;
  logic        fifo_empty;
  logic [32:0] head;

  assign in_ready   = (cnt_q != FULL_CNT) &&
                      ((state_q == S_BEGIN) || (state_q == S_GAP) || (state_q == S_DATA));
  assign push       = bus.in_valid && in_ready;
  assign complete   = wen_q && !bus.stall;
  assign fifo_empty = (cnt_q == '0);
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    wen_d   = wen_q;
    data_d  = data_q;
    wc_d    = wc_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_BEGIN;
          wen_d   = 1'b1;
          data_d  = BEGIN_SYMBOL;
          wc_d    = '0;
        end
      end
      S_BEGIN: begin
        if (complete) begin
          wc_d    = wc_q + 10'd1;
          wen_d   = 1'b0;
          state_d = S_GAP;
          ret_d   = S_DATA;
        end
      end
      // The gap cycle already decides the next write so a fed stream runs at 2 cycles/word.
      S_GAP: begin
        state_d = ret_q;
        if (ret_q == S_END) begin
          wen_d  = 1'b1;
          data_d = END_SYMBOL;
        end else if (!fifo_empty) begin
          wen_d  = 1'b1;
          data_d = head[31:0];
        end
      end
      S_DATA: begin
        if (wen_q) begin
          if (!bus.stall) begin
            pop     = 1'b1;
            wc_d    = wc_q + 10'd1;
            wen_d   = 1'b0;
            state_d = S_GAP;
            ret_d   = head[32] ? S_END : S_DATA;
          end
        end else if (!fifo_empty) begin
          wen_d  = 1'b1;
          data_d = head[31:0];
        end
      end
      S_END: begin
        if (complete) begin
          wc_d    = wc_q + 10'd1;
          wen_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        wen_d   = 1'b0;
      end
    endcase
  end

  // No bypass: push is gated by the registered count, so a full FIFO refuses even while popping.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {bus.in_last, bus.in_data};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ret_q    <= S_DATA;
      wen_q    <= 1'b0;
      data_q   <= '0;
      wc_q     <= '0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      wen_q    <= wen_d;
      data_q   <= data_d;
      wc_q     <= wc_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.wen        = wen_q;
  assign bus.addr       = wen_q ? TEST_PORT : '0;
  assign bus.data       = wen_q ? data_q : '0;
  assign bus.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.word_count = wc_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_test_port_writer.sv
// Bench for test_port_writer: frame table plus directed stall, full, empty, reset and long-frame sequences.
module tb_test_port_writer;

  localparam logic [31:0] BEGIN_SYM = 32'h00000932;
  localparam logic [31:0] END_SYM   = 32'h00000D5D;
  localparam logic [29:0] PORT      = 30'h40;

  typedef struct packed {
    logic [2:0]       n;
    logic [3:0][31:0] w;
    logic [2:0]       stall_on;
    logic [3:0]       stall_len;
    logic             spacing;
    logic [9:0]       exp_wc;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   pushes_acc = 0;
  logic prev_cmp = 1'b0;
  logic [31:0] last_data = '0;

  logic [31:0] exp_q[$];
  logic [32:0] feed_q[$];
  int          wr_cyc[$];
  frame_t      tbl[3];

  test_port_writer_if bus();

  test_port_writer dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: every accepted write is compared against the expected queue.
  always @(negedge clk) begin
    if (rst_n && bus.wen && !bus.stall) begin
      chk("write_addr", 32'(bus.addr), 32'(PORT));
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%0h required=none", bus.data);
      end else begin
        chk("write_data", bus.data, exp_q.pop_front());
      end
      chk("write_isolated", 32'(prev_cmp), 32'd0);
      wr_cyc.push_back(cyc);
      last_data = bus.data;
      prev_cmp  = 1'b1;
    end else begin
      prev_cmp = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic feed();
    logic rdy;
    int   n;
    while (feed_q.size() > 0) begin
      bus.in_valid = 1'b1;
      bus.in_data  = feed_q[0][31:0];
      bus.in_last  = feed_q[0][32];
      n = 0;
      forever begin
        @(negedge clk);
        rdy = bus.in_ready;
        tick();
        n++;
        if (rdy) begin
          pushes_acc++;
          void'(feed_q.pop_front());
          break;
        end
        if (n > 200) begin
          checks++;
          failures++;
          $display("FAIL push_timeout actual=stuck required=accepted");
          feed_q.delete();
          break;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!bus.done && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.done), 32'd1);
  endtask

  task automatic wait_write_of(input logic [31:0] d, input string name);
    int n = 0;
    while (!(bus.wen && bus.data == d) && n < 100) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.wen && bus.data == d), 32'd1);
  endtask

  task automatic stall_handler(input frame_t f);
    logic [9:0] wc0;
    if (f.stall_on < f.n) begin
      wait_write_of(f.w[f.stall_on], "stall_target_seen");
      wc0 = bus.word_count;
      bus.stall = 1'b1;
      for (int i = 0; i < int'(f.stall_len); i++) begin
        tick();
        chk("stall_hold_wen", 32'(bus.wen), 32'd1);
        chk("stall_hold_addr", 32'(bus.addr), 32'(PORT));
        chk("stall_hold_data", bus.data, f.w[f.stall_on]);
      end
      bus.stall = 1'b0;
      tick();
      chk("stall_single_count", 32'(bus.word_count), 32'(wc0 + 10'd1));
    end
  endtask

  function automatic frame_t mk(input logic [2:0] n, input logic [3:0][31:0] w,
                                input logic [2:0] s_on, input logic [3:0] s_len,
                                input logic sp, input logic [9:0] wc);
    frame_t f;
    f.n = n; f.w = w; f.stall_on = s_on; f.stall_len = s_len; f.spacing = sp; f.exp_wc = wc;
    return f;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(3'd4, {32'd2, 32'd1, 32'd1, 32'd0}, 3'd7, 4'd0, 1'b1, 10'd6);
    tbl[1] = mk(3'd1, {32'd0, 32'd0, 32'd0, 32'd3}, 3'd0, 4'd5, 1'b0, 10'd3);
    tbl[2] = mk(3'd3, {32'd0, 32'h00000000, 32'hFFFFFFFF, 32'hA5A50001}, 3'd7, 4'd0, 1'b0, 10'd5);

    rst_n = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.stall = 1'b0;
    tick(); tick();
    chk("rst_wen", 32'(bus.wen), 32'd0);
    chk("rst_addr", 32'(bus.addr), 32'd0);
    chk("rst_data", bus.data, 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_word_count", 32'(bus.word_count), 32'd0);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;

    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(BEGIN_SYM);
      for (int i = 0; i < int'(tbl[r].n); i++) begin
        exp_q.push_back(tbl[r].w[i]);
        feed_q.push_back({(i == int'(tbl[r].n) - 1), tbl[r].w[i]});
      end
      exp_q.push_back(END_SYM);
      wr_cyc.delete();
      pulse_start();
      fork
        feed();
        stall_handler(tbl[r]);
      join
      wait_done(60, "frame_done");
      chk("frame_word_count", 32'(bus.word_count), 32'(tbl[r].exp_wc));
      chk("frame_all_written", 32'(exp_q.size()), 32'd0);
      chk("frame_write_total", 32'(wr_cyc.size()), 32'(tbl[r].n) + 32'd2);
      if (tbl[r].spacing) begin
        for (int i = 1; i < wr_cyc.size(); i++)
          chk("pulse_period", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd2);
      end
    end

    bus.in_valid = 1'b1;
    tick();
    chk("done_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;

    // FIFO fill: BEGIN is held by stall so nothing drains while six words are offered.
    exp_q.push_back(BEGIN_SYM);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(32'h10 + 32'(i));
      feed_q.push_back({(i == 5), 32'h10 + 32'(i)});
    end
    exp_q.push_back(END_SYM);
    pushes_acc = 0;
    bus.stall = 1'b1;
    pulse_start();
    fork
      feed();
      begin
        int n = 0;
        while (pushes_acc < 4 && n < 40) begin
          tick();
          n++;
        end
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        tick(); tick();
        chk("full_accepted", 32'(pushes_acc), 32'd4);
        bus.stall = 1'b0;
      end
    join
    wait_done(60, "full_done");
    chk("full_word_count", 32'(bus.word_count), 32'd8);
    chk("full_all_written", 32'(exp_q.size()), 32'd0);

    exp_q.push_back(BEGIN_SYM);
    exp_q.push_back(32'd610);
    exp_q.push_back(END_SYM);
    wr_cyc.delete();
    pulse_start();
    tick(); tick();
    for (int i = 0; i < 10; i++) chk("empty_wait_wen", 32'(bus.wen), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("empty_still_busy", 32'(bus.busy), 32'd1);
    feed_q.push_back({1'b1, 32'd610});
    feed();
    wait_done(30, "empty_done");
    chk("empty_writes", 32'(wr_cyc.size()), 32'd3);
    if (wr_cyc.size() == 3) chk("empty_end_gap", 32'(wr_cyc[2] - wr_cyc[1]), 32'd2);
    chk("empty_word_count", 32'(bus.word_count), 32'd3);

    exp_q.push_back(BEGIN_SYM);
    exp_q.push_back(32'h55);
    exp_q.push_back(32'h66);
    feed_q.push_back({1'b0, 32'h55});
    feed_q.push_back({1'b0, 32'h66});
    pulse_start();
    fork
      feed();
      wait_write_of(32'h66, "midframe_write_seen");
    join
    bus.stall = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_wen", 32'(bus.wen), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_word_count", 32'(bus.word_count), 32'd0);
    chk("async_rst_data", bus.data, 32'd0);
    exp_q.delete();
    wr_cyc.delete();
    tick();
    rst_n = 1'b1;
    bus.stall = 1'b0;
    exp_q.push_back(BEGIN_SYM);
    exp_q.push_back(32'h77);
    exp_q.push_back(END_SYM);
    feed_q.push_back({1'b1, 32'h77});
    pulse_start();
    feed();
    wait_done(30, "post_rst_done");
    chk("post_rst_word_count", 32'(bus.word_count), 32'd3);
    chk("post_rst_writes", 32'(wr_cyc.size()), 32'd3);

    exp_q.push_back(BEGIN_SYM);
    for (int i = 0; i < 116; i++) begin
      exp_q.push_back(32'(i) * 32'd3 + 32'd1);
      feed_q.push_back({(i == 115), 32'(i) * 32'd3 + 32'd1});
    end
    exp_q.push_back(END_SYM);
    pulse_start();
    fork
      feed();
      begin
        for (int k = 0; k < 3; k++) begin
          for (int j = 0; j < 20; j++) tick();
          if (bus.busy) pulse_start();
        end
      end
    join
    wait_done(100, "long_done");
    chk("long_word_count", 32'(bus.word_count), 32'd118);
    chk("long_final_write", last_data, END_SYM);
    chk("long_all_written", 32'(exp_q.size()), 32'd0);
    tick(); tick();
    chk("long_no_restart", 32'(bus.wen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/test_port_writer.md
Name: test_port_writer

Overview:
- Bus-master stream driver that writes a framed result sequence onto the CPU data-memory write interface (addr/data/wen) at the dedicated test port.
- Frame: BEGIN_SYMBOL, then N result words, then END_SYMBOL.
- It is the producing end of the protocol that the result checker consumes. Intended use: self-checking benches, and replay of golden result streams into the checker.
- Each word is issued as a distinct wen pulse, held through stall and separated by at least one idle cycle. This guarantees the checker counts every word exactly once.

Parameters:
- TEST_PORT, 30'h40, word address driven on addr during every write
- BEGIN_SYMBOL, 32'h00000932, frame-open word
- END_SYMBOL, 32'h00000D5D, frame-close word
- FIFO_DEPTH, 4, input buffer entries (power of 2, at least 2)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a frame; honoured only in IDLE or DONE
- in_valid  input  1  result word offered
- in_data  input  32  result word
- in_last  input  1  marks in_data as the final result of the frame
- in_ready  output  1  FIFO not full and state in {BEGIN, GAP, DATA}
- stall  input  1  memory stall; while high, the current write is not accepted
- addr  output  30  TEST_PORT while wen=1, otherwise 0
- data  output  32  write word while wen=1, otherwise 0
- wen  output  1  write enable
- busy  output  1  high in any state except IDLE and DONE
- done  output  1  high in DONE
- word_count  output  10  completed writes in the current frame, including begin and end words

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; FIFO emptied; wen=0, addr=0, data=0, in_ready=0, busy=0, done=0, word_count=0.
  - Mid-write reset drops wen immediately, without waiting for a clock edge.
- Input handshake: a word is pushed when in_valid and in_ready are both high at a rising edge. Each entry stores {in_last, in_data}.
- FIFO full/empty: full when count=FIFO_DEPTH, in which case in_ready=0. Push and pop in the same cycle are legal, and count is unchanged. A push is never accepted at full, even when a pop occurs that cycle (no bypass). Pointers wrap modulo FIFO_DEPTH.
- Write acceptance: a write completes at a rising edge where wen=1 and stall=0. While stall=1, wen, addr and data hold stable.
- States, all registered outputs:
  - IDLE: wen=0. On start=1, go to BEGIN; word_count is cleared.
  - BEGIN: wen=1, data=BEGIN_SYMBOL. On completion: word_count+1, go to GAP, with return target DATA.
  - GAP: wen=0 for exactly one cycle, then go to the return target (DATA or END).
  - DATA:
    - If the FIFO is empty, wen=0 and the block waits in DATA.
    - Otherwise wen=1 and data=FIFO head. This appears one cycle after the head becomes available.
    - On completion: pop, word_count+1. If the popped entry's last=1, go to GAP with return target END; otherwise go to GAP with return target DATA.
  - END: wen=1, data=END_SYMBOL. On completion: word_count+1, go to DONE.
  - DONE: wen=0, done=1, and word_count holds. start=1 returns to BEGIN with word_count cleared.
- Consequences:
  - Minimum period is 2 cycles per word: 1 write cycle and 1 gap cycle.
  - Two consecutive writes never have wen high across adjacent cycles.
- start while busy=1 is ignored.
- A frame with zero results is not supported. The first data word must exist; END only follows a last-tagged word.
- word_count wraps at 1024 without error indication.
- Stall on a cycle with wen=0 has no effect.
- in_valid in IDLE or DONE is not accepted (in_ready=0).

Test Plan:
- Reset, then start; push 0,1,1,2 with last on 2; stall=0. Required:
  - addr=30'h40 on all 6 wen pulses.
  - Data sequence 932h, 0, 1, 1, 2, D5Dh.
  - Each pulse is 1 cycle wide, with exactly 1 wen=0 cycle between pulses.
  - done=1 with word_count=6.
- Stall=1 for 5 cycles during the write of value 3. Required: wen, addr and data hold 32'd3 for 6 cycles, and the word is written once (word_count increments by 1).
- Push 6 words back-to-back with in_valid held high. Required:
  - in_ready drops after the 4th accepted push.
  - No word is lost or duplicated; output order matches input order.
  - FIFO pointers wrap correctly.
- FIFO empty in DATA for 10 cycles, then push 610 with last. Required: wen=0 throughout the wait, then 610 is written, a 1-cycle gap follows, then D5Dh.
- Assert rst=0 asynchronously while wen=1 in mid-frame. Required:
  - wen=0 and busy=0 immediately.
  - word_count=0.
  - A subsequent start produces a fresh frame beginning with 932h.
- After done, pulse start again and send 116 values with last on the final one. Required:
  - word_count=118.
  - END_SYMBOL is the final write.
  - start pulses issued while busy cause no extra BEGIN.
